rca_chunked_adder_seq: RTL and testbench
========================================

// Module: rca_chunked_adder_seq
// PURPOSE
//   Multi-cycle WIDTH-bit adder built around one ripple_carry_adder_4 instance.
//   Latches both operands on start and feeds the 4-bit adder one nibble per cycle, LSB first.
//   Each nibble's cout is registered as the next nibble's cin; sum nibbles are collected into a result register.
//   Feeds the existing 4-bit RCA and consumes its sum/cout, so wide additions reuse one small adder.
// PARAMETERS
//   WIDTH   16   operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//   NCHUNK  WIDTH/4   localparam; number of nibble cycles per operation
// PORTS
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous reset, active-low
//   start  in   1      request; sampled on clk while state is IDLE or DONE
//   a      in   WIDTH  operand A; captured on the accepted start edge
//   b      in   WIDTH  operand B; captured on the accepted start edge
//   cin    in   1      carry-in for nibble 0; captured with a and b
//   busy   out  1      high while nibbles are being processed
//   done   out  1      one-cycle pulse when sum/cout become valid
//   sum    out  WIDTH  result; holds its value until the next accepted start
//   cout   out  1      carry out of the top nibble; holds like sum
//   ovf    out  1      signed overflow; present only with RCA_SEQ_OVF_EN
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE; busy, done, cout and ovf = 0; sum = 0; operand regs, carry reg and index cleared.
//   FSM states: IDLE -> BUSY on start.
//     BUSY: idx counts 0..NCHUNK-1. Each cycle:
//       - drive the RCA with a_r[4*idx+:4], b_r[4*idx+:4] and carry_r;
//       - write the RCA sum into sum[4*idx+:4] and its cout into carry_r.
//     BUSY -> DONE after nibble NCHUNK-1; at that edge cout <= final carry.
//     DONE lasts one cycle with done=1. DONE -> BUSY if start=1, otherwise DONE -> IDLE.
//   Latency: the start edge is cycle 0. done is high in the cycle after the NCHUNK-th processing edge,
//     i.e. NCHUNK+1 edges after start (5 for WIDTH=16).
//   Back-to-back: start asserted while done=1 is accepted; the new operation begins with no idle cycle.
//   start while BUSY is ignored. The operation is not aborted and the operands are not re-latched.
//   a, b and cin may change freely after the accepted start edge.
//   sum is written nibble by nibble during BUSY. Its value is defined only from done=1 onward;
//     sum and cout then hold until the next accepted start.
//   Wrap-around: the result is modulo 2^WIDTH and the carry appears only on cout.
//     Example: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1.
//   cin=1 with a=b=all-ones -> sum=all-ones, cout=1.
//   Reset mid-operation: immediate return to IDLE; done is not emitted; sum and cout = 0.
// CONFIGURATION
//   RCA_SEQ_OVF_EN defined:
//     - port ovf exists;
//     - ovf = carry into MSB XOR carry out of MSB, registered alongside cout;
//     - 0 on reset; holds like cout.
//   RCA_SEQ_OVF_EN undefined: no ovf port and no related logic. All other behaviour is identical.
// STRUCTURE
//   Shared package rca_pkg:
//     - NIBBLE_W = 4;
//     - state enum/localparams RCA_SEQ_IDLE=2'd0, RCA_SEQ_BUSY=2'd1, RCA_SEQ_DONE=2'd2.
//   Sub-module: exactly one ripple_carry_adder_4 instance as the datapath.
//   The FSM, index counter, carry register and result register are local to this module.
// TESTING (WIDTH=16, plus one WIDTH=4 build)
//   1. a=0xFFFF, b=0x0001, cin=0, 1-cycle start -> busy for 4 cycles; done 5 edges after start;
//      sum=0x0000, cout=1.
//   2. a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
//      With RCA_SEQ_OVF_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
//   3. Back-to-back: op1 0x00FF+0x0001, then start held high in its done cycle with op2 0x8000+0x8000
//      -> first done with sum=0x0100, cout=0; second done exactly 5 edges later with sum=0x0000, cout=1.
//   4. Change a, b and cin and pulse start during BUSY -> result is unchanged from the latched operands
//      and there is no extra done.
//   5. Drop rst_n in the 2nd BUSY cycle -> busy, done and cout fall immediately (no clock edge); sum=0.
//      A start after release gives the correct result.
//   6. WIDTH=4 build: exhaustive a, b, cin (512 cases) -> sum and cout match a+b+cin; done on the 2nd edge.

Source files
------------

// File: rtl/rca_pkg.sv
`default_nettype none
// =============================================================================
// Package  : rca_pkg
// Brief    : Shared nibble width and sequencer state encoding for the chunked
//            ripple-carry adder.
// Revision : 1.0
// =============================================================================
package rca_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] RCA_SEQ_IDLE = 2'd0;
  localparam logic [1:0] RCA_SEQ_BUSY = 2'd1;
  localparam logic [1:0] RCA_SEQ_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = RCA_SEQ_IDLE,
    ST_BUSY = RCA_SEQ_BUSY,
    ST_DONE = RCA_SEQ_DONE
  } rca_seq_state_e;

endpackage : rca_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder_4.sv
`default_nettype none
// =============================================================================
// Module   : ripple_carry_adder_4
// Brief    : Combinational 4-bit ripple-carry adder built from full-adder cells.
// Revision : 1.0
// =============================================================================
module ripple_carry_adder_4
  import rca_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[NIBBLE_W];

endmodule : ripple_carry_adder_4
`default_nettype wire

// File: rtl/rca_chunked_adder_seq.sv
`default_nettype none
// =============================================================================
// Module   : rca_chunked_adder_seq
// Brief    : Multi-cycle WIDTH-bit adder that feeds one 4-bit ripple-carry
//            adder a nibble per cycle, LSB first. Optional signed-overflow
//            output is enabled by defining RCA_SEQ_OVF_EN.
// Revision : 1.0
// =============================================================================
module rca_chunked_adder_seq
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / NIBBLE_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NCHUNK - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("rca_chunked_adder_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  rca_seq_state_e      r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_carry;
  logic                r_busy;
  logic                r_done;
  logic [WIDTH-1:0]    r_sum;
  logic                r_cout;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_rca_sum;
  logic                w_rca_cout;

  // Constant-index mux keeps every slice in range, including the single-nibble build.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_carry_adder_4 u_rca (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_rca_sum),
    .cout (w_rca_cout)
  );

`ifdef RCA_SEQ_OVF_EN
  logic r_ovf;
  logic w_msb_cin;
  logic w_ovf;

  // Carry into the MSB is recovered from the top bit's sum: s = a ^ b ^ c_in.
  assign w_msb_cin = w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1] ^ w_rca_sum[NIBBLE_W-1];
  assign w_ovf     = w_msb_cin ^ w_rca_cout;
  assign ovf       = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_BUSY: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
              r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_rca_sum;
            end
          end
          r_carry <= w_rca_cout;
          if (r_idx == c_last_idx) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_rca_cout;
`ifdef RCA_SEQ_OVF_EN
            r_ovf   <= w_ovf;
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : rca_chunked_adder_seq
`default_nettype wire

// File: tb/tb_rca_chunked_adder_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_rca_chunked_adder_seq
// Brief    : Self-checking bench for a 16-bit and a 4-bit chunked adder
//            against an arithmetic reference. Honours RCA_SEQ_OVF_EN.
// Revision : 1.0
// =============================================================================
module tb_rca_chunked_adder_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4;
  logic [3:0]  sum4;

`ifdef RCA_SEQ_OVF_EN
  logic        ovf, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_chunked_adder_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  rca_chunked_adder_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, hold start over one edge, then scramble the inputs.
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; start = 1'b1;
    step();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
  endtask

  // Edges after the start edge until done; 99 marks an expired bound.
  task automatic wait_done(output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) busy_low++;
      step();
      n++;
    end
    if (done !== 1'b1) n = 99;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, cout, sum} !== 19'd0) begin
      errors++;
      $display("FAIL reset16: got busy=%b done=%b cout=%b sum=%h required all zero", busy, done, cout, sum);
    end
    checks++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4: got busy=%b done=%b cout=%b sum=%h required all zero", busy4, done4, cout4, sum4);
    end
`ifdef RCA_SEQ_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    int n, bl;
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(n, bl);
    checks++;
    if (n != 4 || bl != 0) begin
      errors++;
      $display("FAIL wrap_latency: got edges=%0d busy_gaps=%0d required edges=4 busy_gaps=0", n, bl);
    end
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL wrap_result: got sum=%h cout=%b required sum=0000 cout=1", sum, cout);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL wrap_hold: got done=%b busy=%b sum=%h cout=%b required 0 0 0000 1", done, busy, sum, cout);
    end
  endtask

  task automatic test_basic();
    int n, bl;
    launch(16'h1234, 16'h4321, 1'b1);
    wait_done(n, bl);
    checks++;
    if (n != 4 || sum !== 16'h5556 || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic: got edges=%0d sum=%h cout=%b required edges=4 sum=5556 cout=0", n, sum, cout);
    end
    step();
    launch(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(n, bl);
    checks++;
    if (sum !== 16'hFFFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL all_ones_cin: got sum=%h cout=%b required sum=ffff cout=1", sum, cout);
    end
    step();
`ifdef RCA_SEQ_OVF_EN
    launch(16'h7FFF, 16'h0001, 1'b0);
    wait_done(n, bl);
    checks++;
    if (sum !== 16'h8000 || ovf !== 1'b1 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pos: got sum=%h ovf=%b cout=%b required 8000 1 0", sum, ovf, cout);
    end
    step();
`endif
  endtask

  task automatic test_random();
    int n, bl;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] exp;
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      launch(ra, rb, rc);
      wait_done(n, bl);
      checks++;
      if (n != 4 || bl != 0 || sum !== exp[15:0] || cout !== exp[16]) begin
        errors++;
        $display("FAIL random[%0d]: %h+%h+%b got edges=%0d sum=%h cout=%b required edges=4 sum=%h cout=%b",
                 i, ra, rb, rc, n, sum, cout, exp[15:0], exp[16]);
      end
`ifdef RCA_SEQ_OVF_EN
      checks++;
      if (ovf !== ((ra[15] == rb[15]) && (exp[15] != ra[15]))) begin
        errors++;
        $display("FAIL random_ovf[%0d]: got %b for %h+%h+%b", i, ovf, ra, rb, rc);
      end
`endif
      if ($urandom_range(1, 0) == 1) step();
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n, bl;
    launch(16'h00FF, 16'h0001, 1'b0);
    wait_done(n, bl);
    checks++;
    if (n != 4 || sum !== 16'h0100 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got edges=%0d sum=%h cout=%b required 4 0100 0", n, sum, cout);
    end
    launch(16'h8000, 16'h8000, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    wait_done(n, bl);
    checks++;
    if (n + 1 != 5 || sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got edges=%0d sum=%h cout=%b required 5 0000 1", n + 1, sum, cout);
    end
    step();
    step();
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    logic [15:0] got_sum = '0;
    logic        got_cout = 1'b0;
    launch(16'h0F0F, 16'h00F1, 1'b0);
    step();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        dones++;
        got_sum = sum;
        got_cout = cout;
      end
      step();
    end
    checks++;
    if (dones != 1 || got_sum !== 16'h1000 || got_cout !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: got dones=%0d sum=%h cout=%b required 1 1000 0", dones, got_sum, got_cout);
    end
  endtask

  task automatic test_reset_mid();
    int n, bl;
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(n, bl);
    step();
    launch(16'hAAAA, 16'h5555, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cout !== 1'b0 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b cout=%b sum=%h required 0 0 0 0000", busy, done, cout, sum);
    end
    step();
    rst_n = 1'b1;
    step();
    launch(16'h0F0F, 16'h0101, 1'b1);
    wait_done(n, bl);
    checks++;
    if (n != 4 || sum !== 16'h1011 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: got edges=%0d sum=%h cout=%b required 4 1011 0", n, sum, cout);
    end
    step();
  endtask

  task automatic test_w4_exhaustive();
    logic [4:0] exp;
    int bad = 0;
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8);
      exp = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      step();
      checks++;
      if (done4 !== 1'b1 || sum4 !== exp[3:0] || cout4 !== exp[4]) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL w4[%0d]: got done=%b sum=%h cout=%b required done=1 sum=%h cout=%b",
                   i, done4, sum4, cout4, exp[3:0], exp[4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_basic();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_w4_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rca_chunked_adder_seq
`default_nettype wire
